// File: rtl/pe_row_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_row_drain                                                    |
// | Purpose  : Collects one accumulated sum per PE lane, tags it with the lane |
// |            index, queues it in a FIFO and streams it out over valid/ready. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pe_row_drain #(
  parameter int N       = 4,
  parameter int D_W_ACC = 64,
  parameter int DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N*D_W_ACC-1:0]       in_sum,
  input  logic [N-1:0]               in_valid,
  output logic [D_W_ACC-1:0]         out_data,
  output logic [$clog2(N)-1:0]       out_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int c_IDX_W = $clog2(N);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam int c_ENT_W = c_IDX_W + D_W_ACC;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  // Lane holding stage
  logic [D_W_ACC-1:0] r_hold [N];
  logic [N-1:0]       r_pend;
  logic               r_ovf;

  // FIFO storage; each entry is {lane index, sum}
  logic [c_ENT_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic               w_any;
  logic [c_IDX_W-1:0] w_sel;
  logic               w_pop;
  logic               w_push;
  logic [N-1:0]       w_xfer;
  logic [N-1:0]       w_drop;
  logic [c_ENT_W-1:0] w_head;

  // Pick the lowest-index pending lane (scan downwards so the lowest wins)
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_any = 1'b1;
        w_sel = c_IDX_W'(i);
      end
    end
  end

  // Push/pop decisions; a full FIFO still accepts a push when the head leaves
  always_comb begin
    w_pop  = (r_count != '0) && out_ready;
    w_push = w_any && ((r_count != c_FULL) || w_pop);
    w_xfer = '0;
    for (int i = 0; i < N; i++) begin
      w_xfer[i] = w_push && (w_sel == c_IDX_W'(i));
    end
    w_drop = in_valid & r_pend & ~w_xfer;
  end

  // Lane registers: a lane accepts a new pulse if free or emptying this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      for (int i = 0; i < N; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && (!r_pend[i] || w_xfer[i])) begin
          r_hold[i] <= in_sum[i*D_W_ACC +: D_W_ACC];
        end
        r_pend[i] <= in_valid[i] | (r_pend[i] & ~w_xfer[i]);
      end
    end
  end

  // Sticky overflow: any pulse that lands on an occupied, non-draining lane
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (|w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  // FIFO storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_sel, r_hold[w_sel]};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Show-ahead head; data and index read as zero while empty
  always_comb begin
    w_head    = r_mem[r_rd_ptr];
    out_valid = (r_count != '0);
    out_data  = out_valid ? w_head[D_W_ACC-1:0] : '0;
    out_idx   = out_valid ? w_head[c_ENT_W-1 -: c_IDX_W] : '0;
    count     = r_count;
    overflow  = r_ovf;
  end

endmodule
`default_nettype wire

// File: doc/pe_row_drain.md
Name: pe_row_drain

Overview:
- Result-collection stage directly downstream of a row of N systolic processing elements.
- Captures each PE's accumulated sum on that PE's one-cycle valid pulse and tags it with the lane index.
- Queues results in a FIFO and streams them out one per cycle over a valid/ready interface.
- Tolerates the diagonal skew of PE valid pulses and downstream backpressure without losing data, within the overflow rules below.

Parameters:
- N, 4, number of PE lanes; must be >= 2.
- D_W_ACC, 64, accumulator/result data width, matching the PE out_sum width.
- DEPTH, 16, FIFO entries; must be a power of two and >= 2.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_sum  input  N*D_W_ACC  lane i sum at bits [i*D_W_ACC +: D_W_ACC].
- in_valid  input  N  lane i pulse; in_sum lane i is valid this cycle.
- out_data  output  D_W_ACC  FIFO head sum.
- out_idx  output  $clog2(N)  lane index of the FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts; pop when out_valid && out_ready.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  output  1  sticky flag: a lane result was dropped.

Behaviour:
- Reset (rst=1 at posedge):
  - Clears all lane pending flags, FIFO pointers, count and overflow.
  - Drives out_valid=0, out_data=0, out_idx=0.
  - FIFO contents are discarded.
  - Reset mid-stream loses all queued and pending data; no pops are reported during reset.
- Lane holding stage (one register plus pending bit per lane):
  - in_valid[i]=1 with pending[i]=0: capture in_sum lane i; pending[i]=1 next cycle.
  - in_valid[i]=1 while pending[i]=1 and lane i is not transferring this cycle: new value dropped, held value kept, overflow<=1.
  - in_valid[i]=1 in the same cycle lane i transfers to the FIFO: new value captured, pending stays 1, no overflow.
- Transfer arbiter:
  - Each cycle, the lowest-index pending lane is selected.
  - The selected lane is written to the FIFO, as {index, sum}, when push is allowed. Its pending bit clears.
  - At most one transfer per cycle.
  - Push is allowed when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
- FIFO:
  - Circular buffer with wrap-around pointers of $clog2(DEPTH) bits.
  - count tracks push/pop: +1 on push only, -1 on pop only, unchanged on both or neither.
  - out_data and out_idx show the head entry (show-ahead); both are 0 when empty.
  - out_valid = (count != 0).
  - A pop when empty is impossible, because out_valid gates it.
- Latency:
  - in_valid at cycle t → pending at t+1 → FIFO write at end of t+1 (if selected and room) → out_valid/out_data at t+2.
  - Minimum latency: 2 cycles.
- Throughput: one result in and one out per cycle sustained. Skewed PE pulses (lane i at t+i) therefore never overflow while the consumer keeps up.
- Backpressure:
  - out_ready=0 fills the FIFO.
  - Once full, pending lanes hold their values.
  - Further pulses on a pending lane set overflow.
- overflow clears only on rst.

Test Plan:
- Skewed row: N=4, in_valid lane i pulsed at cycle 10+i with sum 100+i, out_ready=1 → out_valid from cycle 12 to 15, emitting (idx,data) (0,100),(1,101),(2,102),(3,103) in order; overflow=0; count returns to 0.
- Simultaneous pulses: all 4 lanes pulsed in cycle 5, values 7,8,9,10 → emitted lowest index first on four consecutive cycles starting at cycle 7; no overflow.
- FIFO full with backpressure:
  - Stimulus: DEPTH=16, out_ready=0; 20 results pushed as 5 skewed rows.
  - Required: count saturates at 16; out_valid stays high; four lanes remain pending; overflow=0.
  - Then out_ready=1: all 20 results drain in arrival order.
- Lane overrun: lane 2 pulsed with 0xAA while its pending bit is held (FIFO full), then pulsed again with 0xBB → overflow=1 and stays 1; 0xAA is delivered and 0xBB never is.
- Full plus simultaneous pop/push: count=16, out_ready=1, one lane pending → count stays 16 that cycle, head advances, pending lane enters the FIFO.
- Reset mid-operation: rst=1 for one cycle with count=9 and overflow=1 → next cycle count=0, out_valid=0, overflow=0, no stale data emitted afterwards.
